// File: rtl/qp_mem_arbiter_if.sv
// rtl/qp_mem_arbiter_if.sv - requester, response and SRAM signal bundle for qp_mem_arbiter
interface qp_mem_arbiter_if #(
  parameter int ADDRW = 9,
  parameter int PW    = 55
);
  // wbs (Wishbone slave controller) requester
  logic             wbs_mode;
  logic             wbs_req;
  logic             wbs_we;
  logic [ADDRW-1:0] wbs_addr;
  logic [PW-1:0]    wbs_wdata;
  logic             wbs_gnt;
  logic             wbs_rvalid;
  // ANN engine requester
  logic             eng_req;
  logic             eng_burst;
  logic             eng_we;
  logic [ADDRW-1:0] eng_addr;
  logic [PW-1:0]    eng_wdata;
  logic             eng_gnt;
  logic             eng_rvalid;
  // shared read return
  logic [PW-1:0]    rdata;
  // SRAM port 0
  logic             mem_csb0;
  logic             mem_web0;
  logic [ADDRW-1:0] mem_addr0;
  logic [PW-1:0]    mem_wpatch0;
  logic [PW-1:0]    mem_rpatch0;

  modport slave (
    input  wbs_mode, wbs_req, wbs_we, wbs_addr, wbs_wdata,
    input  eng_req, eng_burst, eng_we, eng_addr, eng_wdata,
    input  mem_rpatch0,
    output wbs_gnt, wbs_rvalid, eng_gnt, eng_rvalid, rdata,
    output mem_csb0, mem_web0, mem_addr0, mem_wpatch0
  );

  modport master (
    output wbs_mode, wbs_req, wbs_we, wbs_addr, wbs_wdata,
    output eng_req, eng_burst, eng_we, eng_addr, eng_wdata,
    output mem_rpatch0,
    input  wbs_gnt, wbs_rvalid, eng_gnt, eng_rvalid, rdata,
    input  mem_csb0, mem_web0, mem_addr0, mem_wpatch0
  );
endinterface

// File: rtl/qp_mem_arbiter.sv
// rtl/qp_mem_arbiter.sv - query-patch SRAM arbiter (wbs vs engine); QP_ARB_RDATA_REG_EN adds an rdata output register
module qp_mem_arbiter #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_QUERYS = 408,
  parameter int MAX_BURST  = 16,
  parameter int MAX_WAIT   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  qp_mem_arbiter_if.slave  bus
);
  localparam int PW    = PATCH_SIZE * DATA_WIDTH;
  localparam int ADDRW = $clog2(NUM_QUERYS);
  localparam int BCW   = $clog2(MAX_BURST + 1);
  localparam int WCW   = $clog2(MAX_WAIT + 1);
  localparam logic [BCW-1:0] BURST_CAP = BCW'(MAX_BURST);
  localparam logic [WCW-1:0] WAIT_CAP  = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ENG_OWN, S_WBS_OWN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_hold;
  logic           r_mode_q;
  logic [BCW-1:0] r_burst_cnt;
  logic [WCW-1:0] r_wbs_wait;
  logic [WCW-1:0] r_eng_wait;
  logic           r_rd_wbs;
  logic           r_rd_eng;

  logic           w_wbs_gnt;
  logic           w_eng_gnt;
  logic           w_hold;
  logic           w_cap;
  logic           w_hold_live;
  logic           w_wbs_starved;
  logic           w_eng_starved;

  // Burst hold survives only while the mode is unchanged since the last beat.
  assign w_hold        = (r_state == S_ENG_OWN) && r_hold && (bus.wbs_mode == r_mode_q);
  assign w_cap         = (r_burst_cnt >= BURST_CAP);
  // While an engine burst is being honoured the burst cap bounds the wbs wait, so the
  // wbs starvation counter is frozen for those beats.
  assign w_hold_live   = w_hold && !w_cap;
  assign w_wbs_starved = (r_wbs_wait == WAIT_CAP);
  assign w_eng_starved = (r_eng_wait == WAIT_CAP);

  // Grant decision, next owner and SRAM command mux.
  always_comb begin
    w_wbs_gnt       = 1'b0;
    w_eng_gnt       = 1'b0;
    w_state_nxt     = S_IDLE;
    bus.mem_csb0    = 1'b1;
    bus.mem_web0    = 1'b1;
    bus.mem_addr0   = '0;
    bus.mem_wpatch0 = '0;
    if (rst_n) begin
      if (bus.wbs_req && bus.eng_req) begin
        if (w_wbs_starved)      w_wbs_gnt = 1'b1;
        else if (w_eng_starved) w_eng_gnt = 1'b1;
        else if (w_cap)         w_wbs_gnt = 1'b1;
        else if (w_hold)        w_eng_gnt = 1'b1;
        else if (bus.wbs_mode)  w_wbs_gnt = 1'b1;
        else                    w_eng_gnt = 1'b1;
      end else if (bus.wbs_req) begin
        w_wbs_gnt = 1'b1;
      end else if (bus.eng_req) begin
        w_eng_gnt = 1'b1;
      end
    end
    if (w_wbs_gnt) begin
      w_state_nxt     = S_WBS_OWN;
      bus.mem_csb0    = 1'b0;
      bus.mem_web0    = !bus.wbs_we;
      bus.mem_addr0   = bus.wbs_addr;
      bus.mem_wpatch0 = bus.wbs_wdata;
    end else if (w_eng_gnt) begin
      w_state_nxt     = S_ENG_OWN;
      bus.mem_csb0    = 1'b0;
      bus.mem_web0    = !bus.eng_we;
      bus.mem_addr0   = bus.eng_addr;
      bus.mem_wpatch0 = bus.eng_wdata;
    end
  end

  assign bus.wbs_gnt = w_wbs_gnt;
  assign bus.eng_gnt = w_eng_gnt;

  // Owner state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Burst hold, burst cap counter and saturating starvation counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold      <= 1'b0;
      r_mode_q    <= 1'b0;
      r_burst_cnt <= '0;
      r_wbs_wait  <= '0;
      r_eng_wait  <= '0;
    end else begin
      r_mode_q <= bus.wbs_mode;
      r_hold   <= w_eng_gnt && bus.eng_burst;
      if (w_eng_gnt && bus.wbs_req)
        r_burst_cnt <= w_cap ? BURST_CAP : r_burst_cnt + 1'b1;
      else
        r_burst_cnt <= '0;
      if (w_wbs_gnt)
        r_wbs_wait <= '0;
      else if (bus.wbs_req && !w_hold_live && !w_wbs_starved)
        r_wbs_wait <= r_wbs_wait + 1'b1;
      if (w_eng_gnt)
        r_eng_wait <= '0;
      else if (bus.eng_req && !w_eng_starved)
        r_eng_wait <= r_eng_wait + 1'b1;
    end
  end

  // Remember which requester owns the read now in the SRAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_wbs <= 1'b0;
      r_rd_eng <= 1'b0;
    end else begin
      r_rd_wbs <= w_wbs_gnt && !bus.wbs_we;
      r_rd_eng <= w_eng_gnt && !bus.eng_we;
    end
  end

`ifdef QP_ARB_RDATA_REG_EN
  logic          r_rv_wbs;
  logic          r_rv_eng;
  logic [PW-1:0] r_rdata;

  // Extra output stage: read data and valids retimed by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rv_wbs <= 1'b0;
      r_rv_eng <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rv_wbs <= r_rd_wbs;
      r_rv_eng <= r_rd_eng;
      r_rdata  <= (r_rd_wbs || r_rd_eng) ? bus.mem_rpatch0 : '0;
    end
  end

  assign bus.wbs_rvalid = r_rv_wbs;
  assign bus.eng_rvalid = r_rv_eng;
  assign bus.rdata      = r_rdata;
`else
  assign bus.wbs_rvalid = r_rd_wbs;
  assign bus.eng_rvalid = r_rd_eng;
  assign bus.rdata      = (r_rd_wbs || r_rd_eng) ? bus.mem_rpatch0 : '0;
`endif

endmodule
